// File: rtl/axi_reg_config_loader.sv
// Polls the AXI-Lite control register, then loads, validates and latches image geometry onto cfg_*.
// Optional macro FRAME_COUNTER_EN adds a frame_done counter reported through register 5.
module axi_reg_config_loader #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int POLL_INTERVAL      = 16,
  parameter int MAX_DIM            = 4096
) (
  input  logic                          S_AXI_ACLK,
  input  logic                          S_AXI_ARESETN,
  output logic [1:0]                    register_operation,
  output logic [7:0]                    register_number,
  output logic [C_S_AXI_DATA_WIDTH-1:0] register_write,
  input  logic [C_S_AXI_DATA_WIDTH-1:0] register_read,
  input  logic                          frame_done,
  output logic [15:0]                   cfg_width,
  output logic [15:0]                   cfg_height,
  output logic [C_S_AXI_DATA_WIDTH-1:0] cfg_threshold,
  output logic                          cfg_valid,
  output logic                          cfg_error,
  output logic                          busy
);
  localparam int          DW           = C_S_AXI_DATA_WIDTH;
  localparam logic [15:0] LP_POLL_LAST = 16'(POLL_INTERVAL - 1);
  localparam logic [16:0] LP_MAX_DIM   = 17'(MAX_DIM);

  typedef enum logic [3:0] {
    S_IDLE, S_RD_CTRL, S_RD_W, S_RD_H, S_RD_T, S_CHECK, S_WR_STATUS, S_WR_CTRL, S_WR_FCNT
  } state_t;

  state_t        r_state, w_next;
  logic [1:0]    r_phase;
  logic [15:0]   r_poll;
  logic [DW-1:0] r_ctrl, r_w, r_h, r_t;
  logic          r_ok;
  logic          w_ok, w_last, w_access, w_fpend;
  logic [DW-1:0] w_fcnt_data;

`ifdef FRAME_COUNTER_EN
  logic [31:0] r_fcnt, r_fsnap, w_fcnt_nxt;
  logic        r_fpend;

  assign w_fcnt_nxt  = r_fcnt + {31'd0, frame_done};
  assign w_fpend     = r_fpend;
  assign w_fcnt_data = DW'(r_fsnap);

  // Snapshot includes a pulse landing on the launch edge, so the flag can be cleared there.
  always_ff @(posedge S_AXI_ACLK) begin
    if (!S_AXI_ARESETN) begin
      r_fcnt  <= '0;
      r_fsnap <= '0;
      r_fpend <= 1'b0;
    end else begin
      r_fcnt <= w_fcnt_nxt;
      if (r_state == S_IDLE && w_next == S_WR_FCNT) begin
        r_fpend <= 1'b0;
        r_fsnap <= w_fcnt_nxt;
      end else if (frame_done) begin
        r_fpend <= 1'b1;
      end
    end
  end
`else
  logic w_unused_frame_done;
  assign w_unused_frame_done = frame_done;
  assign w_fpend             = 1'b0;
  assign w_fcnt_data         = '0;
`endif

  always_comb begin
    w_access = !(r_state inside {S_IDLE, S_CHECK});
    w_last   = (r_phase == 2'd2);
    w_ok     = (r_w[DW-1:16] == '0) && (r_h[DW-1:16] == '0) &&
               (r_w[15:0] != '0) && (r_h[15:0] != '0) &&
               ({1'b0, r_w[15:0]} <= LP_MAX_DIM) && ({1'b0, r_h[15:0]} <= LP_MAX_DIM);
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:      if (w_fpend) w_next = S_WR_FCNT;
                   else if (r_poll == LP_POLL_LAST) w_next = S_RD_CTRL;
      S_RD_CTRL:   if (w_last) w_next = r_ctrl[0] ? S_RD_W : S_IDLE;
      S_RD_W:      if (w_last) w_next = S_RD_H;
      S_RD_H:      if (w_last) w_next = S_RD_T;
      S_RD_T:      if (w_last) w_next = S_CHECK;
      S_CHECK:     w_next = S_WR_STATUS;
      S_WR_STATUS: if (w_last) w_next = S_WR_CTRL;
      S_WR_CTRL:   if (w_last) w_next = S_IDLE;
      S_WR_FCNT:   if (w_last) w_next = S_IDLE;
      default:     w_next = S_IDLE;
    endcase
  end

  // Validation result is registered on entry to CHECK so cfg_valid and cfg_* are visible during CHECK.
  always_ff @(posedge S_AXI_ACLK) begin
    if (!S_AXI_ARESETN) begin
      r_state       <= S_IDLE;
      r_phase       <= '0;
      r_poll        <= '0;
      r_ctrl        <= '0;
      r_w           <= '0;
      r_h           <= '0;
      r_t           <= '0;
      r_ok          <= 1'b0;
      cfg_width     <= '0;
      cfg_height    <= '0;
      cfg_threshold <= '0;
      cfg_valid     <= 1'b0;
      cfg_error     <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_phase   <= (w_access && w_next == r_state) ? r_phase + 2'd1 : '0;
      r_poll    <= (r_state == S_IDLE && w_next == S_IDLE) ? r_poll + 16'd1 : '0;
      cfg_valid <= 1'b0;
      if (r_phase == 2'd1) begin
        case (r_state)
          S_RD_CTRL: r_ctrl <= register_read;
          S_RD_W:    r_w    <= register_read;
          S_RD_H:    r_h    <= register_read;
          S_RD_T:    r_t    <= register_read;
          default:   ;
        endcase
      end
      if (r_state == S_RD_T && w_last) begin
        r_ok <= w_ok;
        if (w_ok) begin
          cfg_width     <= r_w[15:0];
          cfg_height    <= r_h[15:0];
          cfg_threshold <= r_t;
          cfg_valid     <= 1'b1;
          cfg_error     <= 1'b0;
        end else begin
          cfg_error <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    register_operation = 2'd0;
    register_number    = '0;
    register_write     = '0;
    if (w_access) begin
      case (r_phase)
        2'd0:    register_operation = (r_state inside {S_WR_STATUS, S_WR_CTRL, S_WR_FCNT}) ? 2'd2 : 2'd1;
        2'd2:    register_operation = 2'd3;
        default: register_operation = 2'd0;
      endcase
    end
    case (r_state)
      S_RD_W:      register_number = 8'd1;
      S_RD_H:      register_number = 8'd2;
      S_RD_T:      register_number = 8'd3;
      S_WR_STATUS: begin
        register_number     = 8'd4;
        register_write[1:0] = {~r_ok, r_ok};
      end
      S_WR_CTRL:   register_write = {r_ctrl[DW-1:1], 1'b0};
      S_WR_FCNT:   begin
        register_number = 8'd5;
        register_write  = w_fcnt_data;
      end
      default:     ;
    endcase
    busy = (r_state != S_IDLE);
  end
endmodule
